// File: rtl/jpeg_stage_sequencer.sv
// ============================================================================
// jpeg_stage_sequencer : drives each 8x8 block through RGB2YCBCR, DCT, QUAN,
//                        HUFF with start/done handshakes; counts blocks/frame.
// Optional feature     : SEQ_WATCHDOG_EN (per-stage wait watchdog, sticky err)
// Revision             : 1.0
// ============================================================================
`default_nettype none

module jpeg_stage_sequencer #(
  parameter int unsigned NUM_BLOCKS     = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic start_rgb,
  output logic start_dct,
  output logic start_quan,
  output logic start_huff,
  input  logic done_rgb,
  input  logic done_dct,
  input  logic done_quan,
  input  logic done_huff,
  output logic [((NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1)-1:0] blk_idx,
  output logic busy,
  output logic frame_done,
  output logic err
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RGB   = 3'd1,
    S_DCT   = 3'd2,
    S_QUAN  = 3'd3,
    S_HUFF  = 3'd4,
    S_FDONE = 3'd5
  } state_t;

  state_t           state_q;
  logic             start_rgb_q, start_dct_q, start_quan_q, start_huff_q;
  logic [IDX_W-1:0] blk_idx_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             err_q;

  logic in_stage;
  logic stage_done;

  always_comb begin
    in_stage   = 1'b0;
    stage_done = 1'b0;
    case (state_q)
      S_RGB:   begin in_stage = 1'b1; stage_done = done_rgb;  end
      S_DCT:   begin in_stage = 1'b1; stage_done = done_dct;  end
      S_QUAN:  begin in_stage = 1'b1; stage_done = done_quan; end
      S_HUFF:  begin in_stage = 1'b1; stage_done = done_huff; end
      default: begin in_stage = 1'b0; stage_done = 1'b0;      end
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
  logic [WAIT_W-1:0] wait_q;
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_rgb_q  <= 1'b0;
      start_dct_q  <= 1'b0;
      start_quan_q <= 1'b0;
      start_huff_q <= 1'b0;
      blk_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wait_q       <= '0;
`endif
    end else if (abort) begin
      // err is deliberately left alone so a watchdog trip survives an abort
      state_q      <= S_IDLE;
      start_rgb_q  <= 1'b0;
      start_dct_q  <= 1'b0;
      start_quan_q <= 1'b0;
      start_huff_q <= 1'b0;
      blk_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wait_q       <= '0;
`endif
    end else begin
      start_rgb_q  <= 1'b0;
      start_dct_q  <= 1'b0;
      start_quan_q <= 1'b0;
      start_huff_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RGB;
            start_rgb_q <= 1'b1;
            blk_idx_q   <= '0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
          end
        end
        S_RGB: begin
          if (done_rgb) begin
            state_q     <= S_DCT;
            start_dct_q <= 1'b1;
          end
        end
        S_DCT: begin
          if (done_dct) begin
            state_q      <= S_QUAN;
            start_quan_q <= 1'b1;
          end
        end
        S_QUAN: begin
          if (done_quan) begin
            state_q      <= S_HUFF;
            start_huff_q <= 1'b1;
          end
        end
        S_HUFF: begin
          if (done_huff) begin
            if (blk_idx_q == LAST_IDX) begin
              state_q      <= S_FDONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q     <= S_RGB;
              start_rgb_q <= 1'b1;
              blk_idx_q   <= blk_idx_q + IDX_W'(1);
            end
          end
        end
        S_FDONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
`ifdef SEQ_WATCHDOG_EN
      // A done in the limit cycle takes precedence over the timeout.
      if (!in_stage || stage_done) begin
        wait_q <= '0;
      end else if (wait_q == WAIT_LIMIT) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        wait_q  <= '0;
      end else begin
        wait_q <= wait_q + WAIT_W'(1);
      end
`endif
    end
  end

`ifndef SEQ_WATCHDOG_EN
  logic unused_stage;
  assign unused_stage = in_stage & stage_done;
`endif

  assign start_rgb  = start_rgb_q;
  assign start_dct  = start_dct_q;
  assign start_quan = start_quan_q;
  assign start_huff = start_huff_q;
  assign blk_idx    = blk_idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_stage_sequencer.sv
// ============================================================================
// tb_jpeg_stage_sequencer : directed bench, NUM_BLOCKS=2 and NUM_BLOCKS=3
//                           instances sharing one stimulus stream.
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_jpeg_stage_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] dn;            // {rgb, dct, quan, huff}

  logic [3:0] st2, st3;      // {rgb, dct, quan, huff}
  logic [0:0] blk2;
  logic [1:0] blk3;
  logic       busy2, busy3, fd2, fd3, err2, err3;

  int n_total = 0;
  int n_bad   = 0;

  jpeg_stage_sequencer #(.NUM_BLOCKS(2), .TIMEOUT_CYCLES(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_rgb(st2[3]), .start_dct(st2[2]), .start_quan(st2[1]), .start_huff(st2[0]),
    .done_rgb(dn[3]), .done_dct(dn[2]), .done_quan(dn[1]), .done_huff(dn[0]),
    .blk_idx(blk2), .busy(busy2), .frame_done(fd2), .err(err2)
  );

  jpeg_stage_sequencer #(.NUM_BLOCKS(3), .TIMEOUT_CYCLES(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_rgb(st3[3]), .start_dct(st3[2]), .start_quan(st3[1]), .start_huff(st3[0]),
    .done_rgb(dn[3]), .done_dct(dn[2]), .done_quan(dn[1]), .done_huff(dn[0]),
    .blk_idx(blk3), .busy(busy3), .frame_done(fd3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] exp_st;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    dn    = 4'b0000;
    tick();
    tick();
    check_val("rst_busy",  32'(busy2), 32'd0);
    check_val("rst_starts", 32'(st2),  32'd0);
    check_val("rst_blk",   32'(blk2),  32'd0);
    check_val("rst_fdone", 32'(fd2),   32'd0);
    check_val("rst_err",   32'(err2),  32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check_val("rst_no_launch", 32'(st2),   32'd0);
    check_val("rst_idle_busy", 32'(busy2), 32'd0);

    // Two blocks, each stage answers 3 cycles after its start pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      exp_st = (((c - 1) % 4 == 0) && (c <= 29)) ? (4'b1000 >> (((c - 1) / 4) % 4)) : 4'b0000;
      check_val($sformatf("lat3_starts_c%0d", c), 32'(st2),   32'(exp_st));
      check_val($sformatf("lat3_blk_c%0d", c),    32'(blk2),  (c >= 17) ? 32'd1 : 32'd0);
      check_val($sformatf("lat3_fdone_c%0d", c),  32'(fd2),   (c == 33) ? 32'd1 : 32'd0);
      check_val($sformatf("lat3_busy_c%0d", c),   32'(busy2), (c <= 33) ? 32'd1 : 32'd0);
      dn = ((c % 4 == 0) && (c <= 32)) ? (4'b1000 >> (((c - 1) / 4) % 4)) : 4'b0000;
      tick();
    end
    dn    = 4'b0000;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Zero-latency stages, three blocks: frame_done 13 cycles after start.
    dn    = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      exp_st = (c <= 12) ? (4'b1000 >> ((c - 1) % 4)) : 4'b0000;
      check_val($sformatf("zl_starts_c%0d", c), 32'(st3),   32'(exp_st));
      check_val($sformatf("zl_blk_c%0d", c),    32'(blk3),  (c <= 12) ? 32'((c - 1) / 4) : 32'd2);
      check_val($sformatf("zl_fdone_c%0d", c),  32'(fd3),   (c == 13) ? 32'd1 : 32'd0);
      check_val($sformatf("zl_busy_c%0d", c),   32'(busy3), (c <= 13) ? 32'd1 : 32'd0);
      tick();
    end
    check_val("zl_err", 32'(err3), 32'd0);
    dn    = 4'b0000;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Stray dones, start mid-frame, abort racing a done.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("stray_rgb_entry", 32'(st3), 32'b1000);
    dn = 4'b0010;
    tick();
    check_val("stray_quan_ignored", 32'(st3),   32'd0);
    check_val("stray_busy",         32'(busy3), 32'd1);
    dn = 4'b1000;
    tick();
    check_val("stray_dct_entry", 32'(st3), 32'b0100);
    dn    = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("midstart_no_restart", 32'(st3),   32'd0);
    check_val("midstart_busy",       32'(busy3), 32'd1);
    abort = 1'b1;
    dn    = 4'b0100;
    tick();
    abort = 1'b0;
    dn    = 4'b0000;
    check_val("abort_busy",   32'(busy3), 32'd0);
    check_val("abort_blk",    32'(blk3),  32'd0);
    check_val("abort_starts", 32'(st3),   32'd0);
    tick();
    check_val("abort_no_quan", 32'(st3), 32'd0);

    // abort and start together in IDLE keeps it idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("abort_start_busy",   32'(busy3), 32'd0);
    check_val("abort_start_starts", 32'(st3),   32'd0);
    tick();
    check_val("abort_start_late", 32'(st3), 32'd0);

`ifdef SEQ_WATCHDOG_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 4'b1000;
    tick();
    dn = 4'b0000;
    check_val("wd_dct_entry", 32'(st3), 32'b0100);
    for (int c = 2; c <= 10; c++) begin
      check_val($sformatf("wd_wait_busy_c%0d", c), 32'(busy3), 32'd1);
      check_val($sformatf("wd_wait_err_c%0d", c),  32'(err3),  32'd0);
      check_val($sformatf("wd_wait_fd_c%0d", c),   32'(fd3),   32'd0);
      tick();
    end
    check_val("wd_trip_busy", 32'(busy3), 32'd0);
    check_val("wd_trip_err",  32'(err3),  32'd1);
    check_val("wd_trip_fd",   32'(fd3),   32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("wd_restart_rgb", 32'(st3),  32'b1000);
    check_val("wd_restart_err", 32'(err3), 32'd0);
    check_val("wd_restart_blk", 32'(blk3), 32'd0);
    dn = 4'b1000;
    tick();
    dn = 4'b0000;
    for (int c = 13; c <= 20; c++) tick();
    dn = 4'b0100;
    tick();
    dn = 4'b0000;
    check_val("wd_edge_quan", 32'(st3),   32'b0010);
    check_val("wd_edge_err",  32'(err3),  32'd0);
    check_val("wd_edge_busy", 32'(busy3), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 4'b1000;
    tick();
    dn = 4'b0100;
    tick();
    dn = 4'b0010;
    tick();
    dn = 4'b0000;
    check_val("stall_huff_entry", 32'(st3), 32'b0001);
    repeat (5000) tick();
    check_val("stall_busy",   32'(busy3), 32'd1);
    check_val("stall_err",    32'(err3),  32'd0);
    check_val("stall_starts", 32'(st3),   32'd0);
    check_val("stall_fd",     32'(fd3),   32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
